// File: rtl/shift_issue_pipe_if.sv
// Issue-side and writeback-side handshake bundle for the shift/rotate stage.
// The master drives operations and out_ready; the slave is the execution stage.
interface shift_issue_pipe_if #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4,
  parameter int TAG_WIDTH     = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OPERAND_WIDTH-1:0] in_data;
  logic [SHAMT_WIDTH-1:0]   in_shamt;
  logic [1:0]               in_op;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPERAND_WIDTH-1:0] out_result;
  logic [TAG_WIDTH-1:0]     out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/shift_issue_pipe.sv
// Shift/rotate execution stage: 2-entry operation FIFO feeding a log-depth
// rotate/shift mux chain, with a registered result held for writeback.
module shift_issue_pipe #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4,
  parameter int TAG_WIDTH     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              busy,
  shift_issue_pipe_if.slave bus
);
  localparam int W = OPERAND_WIDTH;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  // Each set bit of the shift amount enables one power-of-two mux stage.
  function automatic logic [W-1:0] shift_eval(
    input logic [W-1:0]           d,
    input logic [SHAMT_WIDTH-1:0] sh,
    input logic [1:0]             op
  );
    logic [W-1:0] v;
    int           amt;
    v = d;
    for (int k = 0; k < SHAMT_WIDTH; k++) begin
      amt = 1 << k;
      if (sh[k]) begin
        case (op)
          OP_ROL:  v = (v << amt) | (v >> (W - amt));
          OP_SLL:  v = v << amt;
          OP_ROR:  v = (v >> amt) | (v << (W - amt));
          default: v = v >> amt;
        endcase
      end
    end
    return v;
  endfunction

  logic [W-1:0]           data_p0  [2];
  logic [SHAMT_WIDTH-1:0] shamt_p0 [2];
  logic [1:0]             op_p0    [2];
  logic [TAG_WIDTH-1:0]   tag_p0   [2];
  logic [1:0]             count;
  logic                   wr_ptr;
  logic                   rd_ptr;

  logic                   vld_p1;
  logic [W-1:0]           res_p1;
  logic [TAG_WIDTH-1:0]   tag_p1;

  logic                   push;
  logic                   load;
  logic [W-1:0]           head_res_p0;

  assign bus.in_ready = (count != 2'd2);
  assign push         = bus.in_valid & bus.in_ready & ~flush;
  assign load         = (count != 2'd0) & (~vld_p1 | bus.out_ready);
  assign head_res_p0  = shift_eval(data_p0[rd_ptr], shamt_p0[rd_ptr], op_p0[rd_ptr]);

  // Stage p0: FIFO storage, no reset needed since entries are dead while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      data_p0[wr_ptr]  <= bus.in_data;
      shamt_p0[wr_ptr] <= bus.in_shamt;
      op_p0[wr_ptr]    <= bus.in_op;
      tag_p0[wr_ptr]   <= bus.in_tag;
    end
  end

  // Stage p1: FIFO pointers/occupancy and the writeback output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      tag_p1 <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (load) begin
        res_p1 <= head_res_p0;
        tag_p1 <= tag_p0[rd_ptr];
        vld_p1 <= 1'b1;
        rd_ptr <= ~rd_ptr;
      end else if (vld_p1 & bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
      count <= count + {1'b0, push} - {1'b0, load};
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_result = res_p1;
  assign bus.out_tag    = tag_p1;
  assign busy           = (count != 2'd0) | vld_p1;
endmodule

// File: tb/tb_shift_issue_pipe.sv
// Bench for shift_issue_pipe: directed steps plus randomized traffic, checked
// against a transaction-level queue model of the stage.
module tb_shift_issue_pipe;
  localparam int W  = 16;
  localparam int SW = 4;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  shift_issue_pipe_if #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

  shift_issue_pipe #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(SW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    int            acc;
  } item_t;

  item_t q[$];
  int    edge_no = 0;
  int    tests = 0;
  int    fails = 0;

  // Rotations via a doubled operand; shifts via plain zero-filling shifts.
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, int s, logic [1:0] op);
    logic [2*W-1:0] dd;
    logic [W-1:0]   r;
    dd = {d, d};
    case (op)
      2'b00: begin dd = dd << s; r = dd[2*W-1:W]; end
      2'b01: r = d << s;
      2'b10: begin dd = dd >> s; r = dd[W-1:0]; end
      default: r = d >> s;
    endcase
    return r;
  endfunction

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [W-1:0] d, logic [SW-1:0] s, logic [1:0] op, logic [TW-1:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_op    = op;
    bus.in_tag   = t;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 2'b00, '0);
  endtask

  // Check observable state against the model, advance one edge, update model.
  task automatic tick();
    logic  exp_rdy, exp_ov, exp_pop, exp_acc;
    item_t it;
    exp_rdy = (q.size() < 3);
    exp_ov  = (q.size() != 0) && (q[0].acc < edge_no);
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    check("busy", {31'd0, busy}, {31'd0, q.size() != 0});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
    exp_pop = exp_ov && bus.out_ready;
    if (exp_pop) begin
      check("out_result", {16'd0, bus.out_result}, {16'd0, q[0].res});
      check("out_tag", {29'd0, bus.out_tag}, {29'd0, q[0].tag});
    end
    exp_acc = bus.in_valid && exp_rdy;
    it.res = ref_shift(bus.in_data, int'(bus.in_shamt), bus.in_op);
    it.tag = bus.in_tag;
    @(posedge clk);
    edge_no++;
    it.acc = edge_no;
    if (!rst_n || flush) q.delete();
    else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_acc) q.push_back(it);
    end
    #1;
  endtask

  task automatic one_op(logic [W-1:0] d, logic [SW-1:0] s, logic [1:0] op, logic [TW-1:0] t,
                        logic [W-1:0] exp_res, string name);
    bus.out_ready = 1'b1;
    drive(1'b1, d, s, op, t);
    tick();
    idle();
    tick();
    check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({name, "_res"}, {16'd0, bus.out_result}, {16'd0, exp_res});
    check({name, "_tag"}, {29'd0, bus.out_tag}, {29'd0, t});
    tick();
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_result", {16'd0, bus.out_result}, 32'd0);
    check("rst_tag", {29'd0, bus.out_tag}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed op values
    one_op(16'h8001, 4'd1, 2'b10, 3'd5, 16'hC000, "ror");
    one_op(16'h8001, 4'd4, 2'b00, 3'd2, 16'h0018, "rol");
    one_op(16'hFFFF, 4'd15, 2'b01, 3'd3, 16'h8000, "sll");
    one_op(16'h8000, 4'd15, 2'b11, 3'd4, 16'h0001, "srl");
    for (int op = 0; op < 4; op++)
      one_op(16'hA5C3, 4'd0, op[1:0], op[2:0], 16'hA5C3, "sh0");

    // Back-to-back with writeback always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'($urandom), SW'($urandom), 2'($urandom), TW'(i));
      tick();
    end
    idle();
    repeat (3) tick();

    // Backpressure: three held, fourth refused
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, W'($urandom), SW'($urandom), 2'($urandom), TW'(i));
      tick();
    end
    check("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 16'h1234, 4'd3, 2'b01, 3'd4);
    tick();
    idle();
    bus.out_ready = 1'b1;
    tick();
    check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    repeat (4) tick();

    // Flush with three held and a simultaneous push
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, W'($urandom), SW'($urandom), 2'($urandom), TW'(i));
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 16'h5555, 4'd2, 2'b10, 3'd7);
    tick();
    flush = 1'b0;
    idle();
    check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_busy", {31'd0, busy}, 32'd0);
    check("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), W'($urandom), SW'($urandom), 2'($urandom), TW'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Asynchronous reset mid-operation
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'($urandom) | 16'h0001, 4'd1, 2'b10, 3'd6);
      tick();
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_result", {16'd0, bus.out_result}, 32'd0);
    check("ar_tag", {29'd0, bus.out_tag}, 32'd0);
    check("ar_ready", {31'd0, bus.in_ready}, 32'd1);
    check("ar_busy", {31'd0, busy}, 32'd0);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    one_op(16'h0001, 4'd1, 2'b10, 3'd1, 16'h8000, "post_rst");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
